// File: rtl/spectrum_frame_buffer.sv
// Double-buffered spectrum bar-height store: bins fill a back bank, frame_start swaps it to the front.
// Optional macro PEAK_DECAY_EN: written height is max(new, decayed front height) for falling-bar peak hold.
module spectrum_frame_buffer #(
    parameter int unsigned NUM_BINS = 512,
    parameter int unsigned MAG_W    = 16,
    parameter int unsigned SHIFT    = 8,
    parameter int unsigned DECAY    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bin_valid,
    output logic             bin_ready,
    input  logic [8:0]       bin_index,
    input  logic [MAG_W-1:0] bin_mag,
    input  logic             frame_start,
    input  logic [8:0]       address,
    output logic [7:0]       data,
    output logic             front_valid,
    output logic [7:0]       dropped_frames
);

    typedef enum logic {
        FILL,
        WAIT_SWAP
    } state_t;

    state_t     state;
    logic       front_sel;
    logic [7:0] bank0 [NUM_BINS];
    logic [7:0] bank1 [NUM_BINS];

    logic [MAG_W-1:0] scaled_c;
    logic [7:0]       mag8_c;
    logic [7:0]       wr_val_c;
    logic [7:0]       front_rd_c;
    logic             wr_in_range_c;
    logic             rd_in_range_c;
    logic             wr_en_c;
    logic             last_c;

    // Scale and saturate the incoming magnitude to a bar height
    assign scaled_c = bin_mag >> SHIFT;
    assign mag8_c   = (scaled_c > MAG_W'(255)) ? 8'hFF : scaled_c[7:0];

    assign wr_in_range_c = (32'(bin_index) < NUM_BINS);
    assign rd_in_range_c = (32'(address) < NUM_BINS);
    assign wr_en_c       = bin_valid & bin_ready & wr_in_range_c & (state == FILL);
    assign last_c        = wr_en_c & (32'(bin_index) == NUM_BINS - 1);
    assign front_rd_c    = front_sel ? bank1[address] : bank0[address];

`ifdef PEAK_DECAY_EN
    logic [7:0] front_at_bin_c;
    logic [7:0] decayed_c;
    logic [7:0] old_c;

    // Previous displayed height, lowered by DECAY and clamped at zero
    assign front_at_bin_c = front_sel ? bank1[bin_index] : bank0[bin_index];
    assign decayed_c      = (front_at_bin_c > 8'(DECAY)) ? front_at_bin_c - 8'(DECAY) : 8'd0;
    assign old_c          = front_valid ? decayed_c : 8'd0;
    assign wr_val_c       = (mag8_c > old_c) ? mag8_c : old_c;
`else
    assign wr_val_c = mag8_c;
`endif

    // Bank storage is deliberately not reset; front_valid gates its visibility
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            if (front_sel) begin
                bank0[bin_index] <= wr_val_c;
            end else begin
                bank1[bin_index] <= wr_val_c;
            end
        end
    end

    // Fill/swap control, read port and dropped-frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FILL;
            front_sel      <= 1'b0;
            front_valid    <= 1'b0;
            bin_ready      <= 1'b0;
            dropped_frames <= 8'd0;
            data           <= 8'd0;
        end else begin
            data <= (front_valid && rd_in_range_c) ? front_rd_c : 8'd0;

            if (frame_start && (state == FILL) && (dropped_frames != 8'hFF)) begin
                dropped_frames <= dropped_frames + 8'd1;
            end

            case (state)
                FILL: begin
                    bin_ready <= 1'b1;
                    if (last_c) begin
                        state     <= WAIT_SWAP;
                        bin_ready <= 1'b0;
                    end
                end
                WAIT_SWAP: begin
                    bin_ready <= 1'b0;
                    if (frame_start) begin
                        front_sel   <= ~front_sel;
                        front_valid <= 1'b1;
                        state       <= FILL;
                        bin_ready   <= 1'b1;
                    end
                end
                default: begin
                    state     <= FILL;
                    bin_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
